// File: rtl/wbuf_pkg.sv
// wbuf_pkg: shared types and helpers for the parametrised window buffer.
//   mode_t       - CU command codes carried on the mode bus
//   fill_state_t - column-fill sequencer states
//   sel_w()      - width of a select field for N entries (never below 1)
//   cell_idx()   - flattened cell index, row-major
package wbuf_pkg;

    typedef enum logic [2:0] {
        ModeNop       = 3'b000,
        ModeLoadSram  = 3'b001,
        ModeLoadSdram = 3'b010,
        ModeShift     = 3'b011,
        ModeFill      = 3'b100,
        ModeClear     = 3'b101
    } mode_t;

    typedef enum logic {
        StIdle = 1'b0,
        StFill = 1'b1
    } fill_state_t;

    function automatic int unsigned sel_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cell_idx(input int unsigned r, input int unsigned c,
                                             input int unsigned cols);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/window_buffer_param_if.sv
// window_buffer_param_if: CU <-> window buffer command and result bundle.
//   master (CU side) drives enable_CU, mode, row_sel, col_sel, src_sel, data, data_read
//   and observes window, window_valid, busy, fill_done; slave is the buffer side.
interface window_buffer_param_if
    import wbuf_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned WIN_ROWS = 2,
    parameter int unsigned WIN_COLS = 2
);
    localparam int unsigned RowW = sel_w(WIN_ROWS);
    localparam int unsigned ColW = sel_w(WIN_COLS);

    logic                               enable_CU;
    logic [2:0]                         mode;
    logic [RowW-1:0]                    row_sel;
    logic [ColW-1:0]                    col_sel;
    logic                               src_sel;
    logic [DATA_W-1:0]                  data;
    logic [DATA_W-1:0]                  data_read;
    logic [WIN_ROWS*WIN_COLS*DATA_W-1:0] window;
    logic                               window_valid;
    logic                               busy;
    logic                               fill_done;

    modport master (
        output enable_CU, mode, row_sel, col_sel, src_sel, data, data_read,
        input  window, window_valid, busy, fill_done
    );

    modport slave (
        input  enable_CU, mode, row_sel, col_sel, src_sel, data, data_read,
        output window, window_valid, busy, fill_done
    );

endinterface

// File: rtl/wbuf_row.sv
// wbuf_row: one window row of WIN_COLS pixels with per-cell valid bits.
//   clk, nrst        - clock, async active-low reset
//   clear            - drop all valid bits, keep data
//   shift            - shift left; last column keeps data, loses valid
//   wr_cell/wr_col   - single-cell write of cell_data (out-of-range column ignored)
//   wr_last          - write last_data into the last column
//   cells, valid     - column c at cells[c*DATA_W +: DATA_W], valid[c]
// At most one operation is asserted per cycle by the top-level decode.
module wbuf_row #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned WIN_COLS  = 2,
    parameter int unsigned COL_SEL_W = 1
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       clear,
    input  logic                       shift,
    input  logic                       wr_cell,
    input  logic [COL_SEL_W-1:0]       wr_col,
    input  logic [DATA_W-1:0]          cell_data,
    input  logic                       wr_last,
    input  logic [DATA_W-1:0]          last_data,
    output logic [WIN_COLS*DATA_W-1:0] cells,
    output logic [WIN_COLS-1:0]        valid
);
    logic [DATA_W-1:0]   cells_q [WIN_COLS];
    logic [DATA_W-1:0]   cells_d [WIN_COLS];
    logic [WIN_COLS-1:0] valid_q;
    logic [WIN_COLS-1:0] valid_d;

    always_comb begin
        cells_d = cells_q;
        valid_d = valid_q;
        if (clear) begin
            valid_d = '0;
        end else if (shift) begin
            for (int c = 0; c < int'(WIN_COLS) - 1; c++) begin
                cells_d[c] = cells_q[c+1];
                valid_d[c] = valid_q[c+1];
            end
            valid_d[WIN_COLS-1] = 1'b0;
        end else if (wr_last) begin
            cells_d[WIN_COLS-1] = last_data;
            valid_d[WIN_COLS-1] = 1'b1;
        end else if (wr_cell) begin
            // Compare per column so a non-power-of-2 select simply matches nothing.
            for (int c = 0; c < int'(WIN_COLS); c++) begin
                if (wr_col == COL_SEL_W'(c)) begin
                    cells_d[c] = cell_data;
                    valid_d[c] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int c = 0; c < int'(WIN_COLS); c++) cells_q[c] <= '0;
            valid_q <= '0;
        end else begin
            cells_q <= cells_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        cells = '0;
        for (int c = 0; c < int'(WIN_COLS); c++) cells[c*DATA_W +: DATA_W] = cells_q[c];
    end

    assign valid = valid_q;

endmodule

// File: rtl/window_buffer_param.sv
// window_buffer_param: WIN_ROWS x WIN_COLS pixel window loaded under CU command.
//   clk, nrst - clock, async active-low reset
//   bus       - slave side of window_buffer_param_if (commands in, window/status out)
// Holds the FILL sequencer, row counter, command decode and window_valid reduction;
// the cells themselves live in one wbuf_row per row.
module window_buffer_param
    import wbuf_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned WIN_ROWS = 2,
    parameter int unsigned WIN_COLS = 2
) (
    input logic                   clk,
    input logic                   nrst,
    window_buffer_param_if.slave  bus
);
    localparam int unsigned RowW  = sel_w(WIN_ROWS);
    localparam int unsigned ColW  = sel_w(WIN_COLS);
    localparam int unsigned RowBw = WIN_COLS * DATA_W;

    fill_state_t       state_q;
    logic [RowW-1:0]   cnt_q;
    logic              fill_done_q;

    mode_t             cmd;
    logic              idle;
    logic              do_clear;
    logic              do_shift;
    logic              do_load;
    logic              fill_wr;
    logic [RowW-1:0]   fill_row;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] fill_data;

    logic [WIN_ROWS*WIN_COLS*DATA_W-1:0] win_flat;
    logic [WIN_ROWS*WIN_COLS-1:0]        valid_flat;

    assign cmd       = mode_t'(bus.mode);
    assign idle      = (state_q == StIdle);
    assign do_clear  = bus.enable_CU && (cmd == ModeClear);
    assign do_shift  = bus.enable_CU && idle && (cmd == ModeShift);
    assign do_load   = bus.enable_CU && idle &&
                       ((cmd == ModeLoadSram) || (cmd == ModeLoadSdram));
    assign load_data = (cmd == ModeLoadSdram) ? bus.data_read : bus.data;
    // Accept cycle writes row 0; inside FILL every strobe writes except an aborting CLEAR.
    assign fill_wr   = bus.enable_CU &&
                       ((idle && (cmd == ModeFill)) || (!idle && (cmd != ModeClear)));
    assign fill_row  = idle ? '0 : cnt_q;
    assign fill_data = bus.src_sel ? bus.data_read : bus.data;

    for (genvar r = 0; r < int'(WIN_ROWS); r++) begin : g_row
        wbuf_row #(
            .DATA_W   (DATA_W),
            .WIN_COLS (WIN_COLS),
            .COL_SEL_W(ColW)
        ) u_row (
            .clk      (clk),
            .nrst     (nrst),
            .clear    (do_clear),
            .shift    (do_shift),
            .wr_cell  (do_load && (bus.row_sel == RowW'(r))),
            .wr_col   (bus.col_sel),
            .cell_data(load_data),
            .wr_last  (fill_wr && (fill_row == RowW'(r))),
            .last_data(fill_data),
            .cells    (win_flat[cell_idx(r, 0, WIN_COLS)*DATA_W +: RowBw]),
            .valid    (valid_flat[cell_idx(r, 0, WIN_COLS) +: WIN_COLS])
        );
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            fill_done_q <= 1'b0;
        end else begin
            fill_done_q <= 1'b0;
            if (bus.enable_CU) begin
                unique case (state_q)
                    StIdle: begin
                        if (cmd == ModeFill) begin
                            if (WIN_ROWS == 1) begin
                                fill_done_q <= 1'b1;
                            end else begin
                                state_q <= StFill;
                                cnt_q   <= RowW'(1);
                            end
                        end
                    end
                    StFill: begin
                        if (cmd == ModeClear) begin
                            state_q <= StIdle;
                            cnt_q   <= '0;
                        end else if (cnt_q == RowW'(WIN_ROWS - 1)) begin
                            state_q     <= StIdle;
                            cnt_q       <= '0;
                            fill_done_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + RowW'(1);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.window       = win_flat;
    assign bus.window_valid = &valid_flat;
    assign bus.busy         = (state_q == StFill);
    assign bus.fill_done    = fill_done_q;

endmodule

// File: tb/tb_window_buffer_param.sv
// tb_window_buffer_param: directed bench for three geometries (2x2, 3x4, 1x2).
// Expected outputs are queued when a step is driven and compared after the edge.
module tb_window_buffer_param;

    logic clk = 1'b0;
    logic nrst0, nrst1, nrst2;
    always #5 clk = ~clk;

    window_buffer_param_if #(.DATA_W(8), .WIN_ROWS(2), .WIN_COLS(2)) if0 ();
    window_buffer_param_if #(.DATA_W(8), .WIN_ROWS(3), .WIN_COLS(4)) if1 ();
    window_buffer_param_if #(.DATA_W(8), .WIN_ROWS(1), .WIN_COLS(2)) if2 ();

    window_buffer_param #(.DATA_W(8), .WIN_ROWS(2), .WIN_COLS(2)) dut0 (
        .clk(clk), .nrst(nrst0), .bus(if0.slave));
    window_buffer_param #(.DATA_W(8), .WIN_ROWS(3), .WIN_COLS(4)) dut1 (
        .clk(clk), .nrst(nrst1), .bus(if1.slave));
    window_buffer_param #(.DATA_W(8), .WIN_ROWS(1), .WIN_COLS(2)) dut2 (
        .clk(clk), .nrst(nrst2), .bus(if2.slave));

    typedef struct {
        int          dut;
        string       tag;
        logic [95:0] win;
        logic        vld;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    task automatic expect_out(input int d, input string tag, input logic [95:0] w,
                              input logic v, input logic b, input logic dn);
        exp_t e;
        e.dut = d; e.tag = tag; e.win = w; e.vld = v; e.busy = b; e.done = dn;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [95:0] ow;
        logic        ov, ob, od;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.dut)
                0:       begin ow = 96'(if0.window); ov = if0.window_valid;
                               ob = if0.busy; od = if0.fill_done; end
                1:       begin ow = if1.window; ov = if1.window_valid;
                               ob = if1.busy; od = if1.fill_done; end
                default: begin ow = 96'(if2.window); ov = if2.window_valid;
                               ob = if2.busy; od = if2.fill_done; end
            endcase
            total++;
            assert (ow === e.win) passed++;
            else $error("FAIL %s window got %h want %h", e.tag, ow, e.win);
            total++;
            assert (ov === e.vld) passed++;
            else $error("FAIL %s window_valid got %b want %b", e.tag, ov, e.vld);
            total++;
            assert (ob === e.busy) passed++;
            else $error("FAIL %s busy got %b want %b", e.tag, ob, e.busy);
            total++;
            assert (od === e.done) passed++;
            else $error("FAIL %s fill_done got %b want %b", e.tag, od, e.done);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic idle_all();
        if0.enable_CU = 1'b0; if1.enable_CU = 1'b0; if2.enable_CU = 1'b0;
    endtask

    task automatic drive(input int d, input logic en, input logic [2:0] m, input int r,
                         input int c, input logic src, input logic [7:0] dt,
                         input logic [7:0] dr);
        case (d)
            0: begin
                if0.enable_CU = en; if0.mode = m; if0.row_sel = 1'(r); if0.col_sel = 1'(c);
                if0.src_sel = src; if0.data = dt; if0.data_read = dr;
            end
            1: begin
                if1.enable_CU = en; if1.mode = m; if1.row_sel = 2'(r); if1.col_sel = 2'(c);
                if1.src_sel = src; if1.data = dt; if1.data_read = dr;
            end
            default: begin
                if2.enable_CU = en; if2.mode = m; if2.row_sel = 1'(r); if2.col_sel = 1'(c);
                if2.src_sel = src; if2.data = dt; if2.data_read = dr;
            end
        endcase
    endtask

    function automatic logic [95:0] w3x4(input logic [7:0] c3, input logic [7:0] c7,
                                         input logic [7:0] c11);
        logic [95:0] w;
        w = '0;
        w[3*8 +: 8]  = c3;
        w[7*8 +: 8]  = c7;
        w[11*8 +: 8] = c11;
        return w;
    endfunction

    initial begin
        nrst0 = 1'b0; nrst1 = 1'b0; nrst2 = 1'b0;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 3'b000, 0, 0, 1'b0, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        #3;
        nrst0 = 1'b1; nrst1 = 1'b1; nrst2 = 1'b1;

        // Reset state
        expect_out(0, "rst_2x2", 96'h0, 1'b0, 1'b0, 1'b0);
        expect_out(1, "rst_3x4", 96'h0, 1'b0, 1'b0, 1'b0);
        expect_out(2, "rst_1x2", 96'h0, 1'b0, 1'b0, 1'b0);
        step();

        // 2x2: four single-cell loads, valid only after the last
        idle_all(); drive(0, 1'b1, 3'b001, 0, 0, 1'b0, 8'h01, 8'hEE);
        expect_out(0, "load00", 96'h00000001, 1'b0, 1'b0, 1'b0); step();
        idle_all(); drive(0, 1'b1, 3'b001, 0, 1, 1'b0, 8'h02, 8'hEE);
        expect_out(0, "load01", 96'h00000201, 1'b0, 1'b0, 1'b0); step();
        idle_all(); drive(0, 1'b1, 3'b010, 1, 0, 1'b0, 8'hEE, 8'h03);
        expect_out(0, "load10", 96'h00030201, 1'b0, 1'b0, 1'b0); step();
        idle_all(); drive(0, 1'b1, 3'b010, 1, 1, 1'b0, 8'hEE, 8'h04);
        expect_out(0, "load11", 96'h04030201, 1'b1, 1'b0, 1'b0); step();

        // No-change cases: strobe low, reserved code
        idle_all(); drive(0, 1'b0, 3'b001, 0, 0, 1'b0, 8'hAA, 8'hAA);
        expect_out(0, "en_low", 96'h04030201, 1'b1, 1'b0, 1'b0); step();
        idle_all(); drive(0, 1'b1, 3'b110, 0, 0, 1'b0, 8'hAA, 8'hAA);
        expect_out(0, "rsvd110", 96'h04030201, 1'b1, 1'b0, 1'b0); step();

        // Shift then two-row fill from SRAM
        idle_all(); drive(0, 1'b1, 3'b011, 0, 0, 1'b0, 8'h00, 8'h00);
        expect_out(0, "shift", 96'h04040202, 1'b0, 1'b0, 1'b0); step();
        idle_all(); drive(0, 1'b1, 3'b100, 0, 0, 1'b0, 8'h09, 8'hEE);
        expect_out(0, "fill_r0", 96'h04040902, 1'b0, 1'b1, 1'b0); step();
        idle_all(); drive(0, 1'b1, 3'b000, 0, 0, 1'b0, 8'h0A, 8'hEE);
        expect_out(0, "fill_r1", 96'h0A040902, 1'b1, 1'b0, 1'b1); step();

        // New FILL accepted while fill_done is high, then aborted by CLEAR
        idle_all(); drive(0, 1'b1, 3'b100, 0, 0, 1'b0, 8'h11, 8'hEE);
        expect_out(0, "refill", 96'h0A041102, 1'b1, 1'b1, 1'b0); step();
        idle_all(); drive(0, 1'b1, 3'b101, 0, 0, 1'b0, 8'h22, 8'hEE);
        expect_out(0, "clear_abort", 96'h0A041102, 1'b0, 1'b0, 1'b0); step();
        idle_all(); drive(0, 1'b0, 3'b000, 0, 0, 1'b0, 8'h00, 8'h00);
        expect_out(0, "no_done", 96'h0A041102, 1'b0, 1'b0, 1'b0); step();

        // 3x4: out-of-range row ignored, then gapped fill from SDRAM
        idle_all(); drive(1, 1'b1, 3'b001, 3, 0, 1'b0, 8'h55, 8'h00);
        expect_out(1, "oor_row", 96'h0, 1'b0, 1'b0, 1'b0); step();
        idle_all(); drive(1, 1'b1, 3'b100, 0, 0, 1'b1, 8'hEE, 8'h05);
        expect_out(1, "g_fill0", w3x4(8'h05, 8'h00, 8'h00), 1'b0, 1'b1, 1'b0); step();
        idle_all(); drive(1, 1'b0, 3'b000, 0, 0, 1'b1, 8'hEE, 8'h63);
        expect_out(1, "g_gap1", w3x4(8'h05, 8'h00, 8'h00), 1'b0, 1'b1, 1'b0); step();
        idle_all(); drive(1, 1'b0, 3'b001, 0, 0, 1'b1, 8'hEE, 8'h63);
        expect_out(1, "g_gap2", w3x4(8'h05, 8'h00, 8'h00), 1'b0, 1'b1, 1'b0); step();
        idle_all(); drive(1, 1'b1, 3'b011, 0, 0, 1'b1, 8'hEE, 8'h06);
        expect_out(1, "g_fill1", w3x4(8'h05, 8'h06, 8'h00), 1'b0, 1'b1, 1'b0); step();
        idle_all(); drive(1, 1'b1, 3'b000, 0, 0, 1'b1, 8'hEE, 8'h07);
        expect_out(1, "g_fill2", w3x4(8'h05, 8'h06, 8'h07), 1'b0, 1'b0, 1'b1); step();
        idle_all(); drive(1, 1'b0, 3'b000, 0, 0, 1'b1, 8'hEE, 8'h00);
        expect_out(1, "g_after", w3x4(8'h05, 8'h06, 8'h07), 1'b0, 1'b0, 1'b0); step();

        // 3x4: reset in the middle of a fill clears everything without a clock edge
        idle_all(); drive(1, 1'b1, 3'b100, 0, 0, 1'b1, 8'hEE, 8'h08);
        expect_out(1, "r_fill0", w3x4(8'h08, 8'h06, 8'h07), 1'b0, 1'b1, 1'b0); step();
        idle_all();
        #2;
        nrst1 = 1'b0;
        #1;
        expect_out(1, "async_rst", 96'h0, 1'b0, 1'b0, 1'b0);
        drain();
        #1;
        nrst1 = 1'b1;
        expect_out(1, "post_rst", 96'h0, 1'b0, 1'b0, 1'b0); step();

        // 1x2: fill completes in the accept cycle, busy never rises
        idle_all(); drive(2, 1'b1, 3'b100, 0, 0, 1'b0, 8'h33, 8'hEE);
        expect_out(2, "r1_fill", 96'h3300, 1'b0, 1'b0, 1'b1); step();
        idle_all(); drive(2, 1'b0, 3'b000, 0, 0, 1'b0, 8'h00, 8'h00);
        expect_out(2, "r1_after", 96'h3300, 1'b0, 1'b0, 1'b0); step();
        idle_all(); drive(2, 1'b1, 3'b001, 0, 0, 1'b0, 8'h44, 8'hEE);
        expect_out(2, "r1_load", 96'h3344, 1'b1, 1'b0, 1'b0); step();
        idle_all(); drive(2, 1'b1, 3'b011, 0, 0, 1'b0, 8'h00, 8'h00);
        expect_out(2, "r1_shift", 96'h3333, 1'b0, 1'b0, 1'b0); step();

        idle_all();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
